// File: rtl/tt_sweep_pkg.sv
// -----------------------------------------------------------------------------
// tt_sweep_pkg
//   Shared types and constants for the truth-table sweep/capture stage.
//   DEF_N_IN : default number of inputs of the function under test
//   TT_W     : truth table width at the default input count (2**DEF_N_IN)
//   CNT_W    : ones-count width at the default input count (holds 0..TT_W)
//   HOLD_W   : width of the per-pattern settle/hold counter (SETTLE 0..15)
//   state_e  : sweep controller states
// -----------------------------------------------------------------------------
package tt_sweep_pkg;

    localparam int DEF_N_IN = 7;
    localparam int TT_W     = 2 ** DEF_N_IN;
    localparam int CNT_W    = DEF_N_IN + 1;
    localparam int HOLD_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_e;

endpackage

// File: rtl/tt_sweep_capture.sv
// -----------------------------------------------------------------------------
// tt_sweep_capture
//   Drives every input pattern 0..2**N_IN-1 onto x_out, samples the 1-bit
//   response f_in of the external combinational function, and assembles the
//   full truth table plus a ones count.
//
//   Parameters
//     N_IN    number of function inputs (truth table is 2**N_IN bits)
//     SETTLE  extra cycles each pattern is held before f_in is sampled (0..15)
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   synchronous active-high reset
//     start      in   request a sweep; honoured only in IDLE
//     f_in       in   function output for the current x_out
//     x_out      out  pattern presented to the function (bit 0 = x0)
//     busy       out  high while a sweep is in progress
//     done       out  one-cycle pulse when the table is complete
//     tt_valid   out  tt_out/ones_count hold a complete sweep
//     tt_out     out  truth table, bit k = f(k)
//     ones_count out  number of patterns with f == 1
// -----------------------------------------------------------------------------
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 f_in,
    output logic [N_IN-1:0]      x_out,
    output logic                 busy,
    output logic                 done,
    output logic                 tt_valid,
    output logic [2**N_IN-1:0]   tt_out,
    output logic [N_IN:0]        ones_count
);

    localparam int TW = 2 ** N_IN;
    localparam int CW = N_IN + 1;

    localparam logic [N_IN-1:0]   X_LAST    = '1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE);

    state_e              state_q,  state_d;
    logic [N_IN-1:0]     x_q,      x_d;
    logic [HOLD_W-1:0]   hold_q,   hold_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                valid_q,  valid_d;
    logic [TW-1:0]       tt_q,     tt_d;
    logic [CW-1:0]       ones_q,   ones_d;

    // Next-state logic. All outputs are registered, so every output change
    // lands on the same edge as the state transition that causes it.
    always_comb begin
        // NOTE: every variable gets a default first; without it a path that
        // skips an assignment would infer a latch.
        state_d = state_q;
        x_d     = x_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        tt_d    = tt_q;
        ones_d  = ones_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    busy_d  = 1'b1;
                    x_d     = '0;
                    hold_d  = '0;
                    valid_d = 1'b0;
                    tt_d    = '0;
                    ones_d  = '0;
                end
            end

            SWEEP: begin
                // f_in is sampled only on the edge that ends the last hold
                // cycle, giving the function SETTLE extra cycles to settle.
                if (hold_q == HOLD_LAST) begin
                    hold_d             = '0;
                    tt_d[x_q +: 1]     = f_in;
                    ones_d             = ones_q + CW'(f_in);
                    if (x_q == X_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        x_d     = '0;
                    end else begin
                        x_d = x_q + N_IN'(1);
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            DONE: begin
                // start is deliberately not looked at here: one cycle back
                // to IDLE, after which a new request is accepted.
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous and also clears the truth table register,
    // so an aborted sweep never leaves a partial table visible.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            tt_q    <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
        end
    end

    assign x_out      = x_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign tt_valid   = valid_q;
    assign tt_out     = tt_q;
    assign ones_count = ones_q;

endmodule
